vending_multi: RTL

Parametrised vending-machine controller for the lab5 vending series. After reset it loads `PRODUCT_NUM` prices serially from `DI`, then enters a vend phase: it accumulates inserted money across cycles, dispenses on a valid selection, and returns change through registered outputs. It adds several features to the fixed three-product vending block:
- configurable product count and data width;
- carried-over credit;
- cancel/refund;
- an optional per-product stock limit.

---
 rtl/vending_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vending_multi.sv
// Multi-product vending controller: serial price load, then vend with carried credit,
// cancel/refund and saturating money sum. Define VENDING_STOCK_EN for per-product stock limits.

module vending_slot #(
    parameter int DATA_W     = 8,
    parameter int STOCK_INIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
`ifdef VENDING_STOCK_EN
    input  logic              take,
    output logic              empty,
`endif
    output logic [DATA_W-1:0] price
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      price <= '0;
        else if (load) price <= din;
    end

`ifdef VENDING_STOCK_EN
    // one spare bit of width avoids a zero-width counter when STOCK_INIT is 0
    localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    logic [STK_W-1:0] stock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       stock <= STK_W'(STOCK_INIT);
        else if (take && stock != '0)   stock <= stock - STK_W'(1);
    end

    assign empty = (stock == '0);
`endif

endmodule

module vending_multi #(
    parameter int PRODUCT_NUM = 3,
    parameter int DATA_W      = 8,
    parameter int SEL_W       = $clog2(PRODUCT_NUM + 1),
    parameter int STOCK_INIT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      DI,
    input  logic [DATA_W-1:0]      MI,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   cancel,
    output logic [DATA_W-1:0]      MO,
    output logic [SEL_W-1:0]       PO,
    output logic                   ready,
    output logic [PRODUCT_NUM-1:0] sold_out
);

    localparam int IDX_W = (PRODUCT_NUM > 1) ? $clog2(PRODUCT_NUM) : 1;

    typedef enum logic {LOAD, VEND} state_t;

    state_t                             state, state_nx;
    logic [IDX_W-1:0]                   idx;
    logic                               last_idx;
    logic [PRODUCT_NUM-1:0][DATA_W-1:0] price;
    logic [PRODUCT_NUM-1:0]             load;
    logic [PRODUCT_NUM-1:0]             empty;
    logic [DATA_W:0]                    sum_w;
    logic [DATA_W-1:0]                  sum, psel, credit, credit_nx, mo_nx;
    logic [SEL_W-1:0]                   po_nx;
    logic                               hit, esel;

    assign last_idx = (idx == IDX_W'(PRODUCT_NUM - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == LOAD && last_idx) state_nx = VEND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          idx <= '0;
        else if (state == LOAD && !last_idx) idx <= idx + IDX_W'(1);
    end

    for (genvar g = 0; g < PRODUCT_NUM; g++) begin : g_slot
        assign load[g] = (state == LOAD) && (idx == IDX_W'(g));
        vending_slot #(
            .DATA_W     (DATA_W),
            .STOCK_INIT (STOCK_INIT)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .din   (DI),
`ifdef VENDING_STOCK_EN
            .take  (po_nx == SEL_W'(g + 1)),
            .empty (empty[g]),
`endif
            .price (price[g])
        );
    end

`ifndef VENDING_STOCK_EN
    assign empty = '0;
`endif
    assign sold_out = empty;

    // saturate rather than wrap so an overflowing credit can never look cheap
    assign sum_w = {1'b0, credit} + {1'b0, MI};
    assign sum   = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];

    always_comb begin
        hit  = 1'b0;
        psel = '0;
        esel = 1'b0;
        for (int i = 0; i < PRODUCT_NUM; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                hit  = 1'b1;
                psel = price[i];
                esel = empty[i];
            end
        end
    end

    always_comb begin
        mo_nx     = '0;
        po_nx     = '0;
        credit_nx = credit;
        if (state == VEND) begin
            if (cancel) begin
                mo_nx     = sum;
                credit_nx = '0;
            end else if (hit && !esel && sum >= psel) begin
                po_nx     = sel;
                mo_nx     = sum - psel;
                credit_nx = '0;
            end else begin
                credit_nx = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MO     <= '0;
            PO     <= '0;
            credit <= '0;
        end else begin
            MO     <= mo_nx;
            PO     <= po_nx;
            credit <= credit_nx;
        end
    end

    assign ready = (state == VEND);

endmodule
